// File: rtl/prewish_pkg.sv
// Shared constants and state encoding for the prewish mentor/student link.
package prewish_pkg;

  localparam int MASK_W          = 8;
  localparam int TICK_CYCLES_SIM = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/prewish_tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_CYCLES enabled cycles.
module prewish_tick_gen #(
  parameter int TICK_CYCLES = 1500000
) (
  input  logic CLK_I,
  input  logic RST_I,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] count;

  // clr suppresses the tick so a reload never coincides with a step
  assign tick = en & ~clr & (count == LAST);

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/prewish_blinky_student.sv
// Captures a blink mask on a mentor strobe edge and plays it MSB first on
// the LED, one bit per prescaler tick, repeating until a new mask arrives.
module prewish_blinky_student #(
  parameter int MASK_W      = prewish_pkg::MASK_W,
  parameter int TICK_CYCLES = 1500000
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              STB_I,
  input  logic [MASK_W-1:0] DAT_I,
  output logic              ACK_O,
  output logic              o_led,
  output logic              o_busy
);

  import prewish_pkg::*;

  localparam int IW = (MASK_W > 1) ? $clog2(MASK_W) : 1;
  localparam logic [IW-1:0] MSB_IDX = IW'(MASK_W - 1);

  // Handshake: a mask is taken on the cycle STB_I is seen rising; ACK_O is
  // high for exactly the following cycle. There is no back-pressure.
  logic              stb_d;
  logic              stb_armed;
  logic              rise;
  logic [MASK_W-1:0] mask;
  logic [IW-1:0]     bit_idx;
  logic              tick;
  state_t            state;
  state_t            state_next;

  // stb_armed blocks a strobe that was already high when reset released
  assign rise = STB_I & ~stb_d & stb_armed;

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      stb_d     <= 1'b0;
      stb_armed <= 1'b0;
      mask      <= '0;
      bit_idx   <= MSB_IDX;
      ACK_O     <= 1'b0;
    end else begin
      stb_d <= STB_I;
      if (!STB_I) begin
        stb_armed <= 1'b1;
      end
      ACK_O <= rise;
      if (rise) begin
        mask    <= DAT_I;
        bit_idx <= MSB_IDX;
      end else if (tick) begin
        bit_idx <= (bit_idx == '0) ? MSB_IDX : bit_idx - 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    o_busy     = 1'b0;
    o_led      = 1'b0;
    case (state)
      IDLE: begin
        if (rise && (DAT_I != '0)) begin
          state_next = RUN;
        end
      end
      RUN: begin
        o_busy = 1'b1;
        o_led  = mask[bit_idx];
        if (rise && (DAT_I == '0)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  prewish_tick_gen #(
    .TICK_CYCLES (TICK_CYCLES)
  ) u_tick_gen (
    .CLK_I (CLK_I),
    .RST_I (RST_I),
    .clr   (rise | (state != RUN)),
    .en    (state == RUN),
    .tick  (tick)
  );

endmodule

// File: tb/tb_prewish_blinky_student.sv
// Bench for prewish_blinky_student: directed scenarios with hand-computed LED
// sequences plus a cycle-count reference model feeding an expected queue.
module tb_prewish_blinky_student;

  import prewish_pkg::*;

  localparam int MW   = MASK_W;
  localparam int TICK = TICK_CYCLES_SIM;

  logic          CLK_I = 1'b0;
  logic          RST_I = 1'b0;
  logic          STB_I = 1'b0;
  logic [MW-1:0] DAT_I = '0;
  logic          ACK_O;
  logic          o_led;
  logic          o_busy;

  int checks = 0;
  int errors = 0;
  int cycles = 0;

  // {ack, busy, led} expected after each rising edge
  logic [2:0] exp_q[$];

  prewish_blinky_student #(
    .MASK_W      (MW),
    .TICK_CYCLES (TICK)
  ) dut (
    .CLK_I  (CLK_I),
    .RST_I  (RST_I),
    .STB_I  (STB_I),
    .DAT_I  (DAT_I),
    .ACK_O  (ACK_O),
    .o_led  (o_led),
    .o_busy (o_busy)
  );

  // ---------------- clock / watchdog ----------------
  always #5 CLK_I = ~CLK_I;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  // LED is derived from cycles elapsed since the last load, not from a bit index.
  logic [MW-1:0] m_mask = '0;
  logic          m_run = 1'b0;
  logic          m_ack = 1'b0;
  logic          m_prev = 1'b0;
  logic          m_seen_low = 1'b0;
  int            m_cnt = 0;

  always @(posedge CLK_I) begin
    logic m_rise;
    logic m_led;
    cycles++;
    if (!RST_I) begin
      m_mask = '0; m_run = 1'b0; m_ack = 1'b0; m_prev = 1'b0;
      m_seen_low = 1'b0; m_cnt = 0;
      exp_q.push_back(3'b000);
    end else begin
      m_rise = STB_I && !m_prev && m_seen_low;
      if (!STB_I) m_seen_low = 1'b1;
      m_prev = STB_I;
      m_ack  = m_rise;
      if (m_rise) begin
        m_mask = DAT_I;
        m_run  = (DAT_I != '0);
        m_cnt  = 0;
      end else if (m_run) begin
        m_cnt = (m_cnt + 1) % (TICK * MW);
      end
      m_led = m_run ? m_mask[MW - 1 - m_cnt / TICK] : 1'b0;
      exp_q.push_back({m_ack, m_run, m_led});
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge CLK_I) begin
    logic [2:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("scoreboard", {29'd0, ACK_O, o_busy, o_led}, {29'd0, (RST_I ? e : 3'b000)});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK_I);
      #1;
    end
  endtask

  task automatic pulse(input logic [MW-1:0] d);
    STB_I = 1'b1;
    DAT_I = d;
    step(1);
    STB_I = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [MW-1:0] pat;
    logic [MW-1:0] pat2;
    int acks;
    pat  = 8'b1011_0100;
    pat2 = 8'b0100_0000;

    // reset, then idle
    step(3);
    check("reset_outputs", {29'd0, ACK_O, o_busy, o_led}, 32'd0);
    RST_I = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("idle_outputs", {29'd0, ACK_O, o_busy, o_led}, 32'd0);
    end

    // single pulse: 32-cycle pattern then wraps to the MSB
    pulse(pat);
    for (int i = 0; i < 36; i++) begin
      check("play_ack", {31'd0, ACK_O}, {31'd0, (i == 0)});
      check("play_busy", {31'd0, o_busy}, 32'd1);
      check("play_led", {31'd0, o_led}, {31'd0, pat[MW - 1 - (i / TICK) % MW]});
      step(1);
    end

    // strobe held high: one acceptance only
    STB_I = 1'b1;
    DAT_I = 8'hFF;
    acks  = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      acks += int'(ACK_O);
      check("held_led", {31'd0, o_led}, 32'd1);
    end
    STB_I = 1'b0;
    step(2);
    check("held_ack_count", acks, 32'd1);

    // zero mask returns to idle
    pulse(8'h00);
    check("zero_ack", {31'd0, ACK_O}, 32'd1);
    check("zero_busy", {31'd0, o_busy}, 32'd0);
    check("zero_led", {31'd0, o_led}, 32'd0);
    step(3);

    // new mask on the tick that leaves bit 3: acceptance wins
    pulse(pat);
    step(19);
    check("pre_win_led", {31'd0, o_led}, 32'd0);
    STB_I = 1'b1;
    DAT_I = pat2;
    step(1);
    STB_I = 1'b0;
    for (int i = 0; i < 32; i++) begin
      check("win_led", {31'd0, o_led}, {31'd0, (i >= 4 && i < 8)});
      step(1);
    end

    // asynchronous reset between edges, strobe high across release
    pulse(8'hFF);
    step(2);
    #2;
    RST_I = 1'b0;
    STB_I = 1'b1;
    #1;
    check("async_rst_outputs", {29'd0, ACK_O, o_busy, o_led}, 32'd0);
    step(2);
    RST_I = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("post_rst_no_accept", {30'd0, ACK_O, o_busy}, 32'd0);
    end
    STB_I = 1'b0;
    step(2);

    // random gaps and masks, checked by the scoreboard every cycle
    while (cycles < 11000) begin
      step($urandom_range(1, 40));
      STB_I = 1'b1;
      DAT_I = MW'($urandom_range(0, 255));
      step($urandom_range(1, 3));
      STB_I = 1'b0;
    end

    step(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
